lut_multi_ram: RTL and testbench

- Parametrised successor to the fixed 16x2 multi-read LUT memory cell model.
- Provides one read/write port plus NREAD read-only ports.
- Configurable geometry, byte-enabled writes, optional registered reads with selectable read-during-write transparency, and an INIT-reload sequencer run after reset.
- Serves as the behavioural model for memlib LUT-RAM mapping tests.

---
 rtl/lut_multi_ram_if.sv | 37 +++
 rtl/lut_multi_ram.sv | 157 +++++++++++++++
 tb/tb_lut_multi_ram.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/lut_multi_ram_if.sv
// lut_multi_ram_if: bus bundle for lut_multi_ram.
//   PORT_RW_ADDR     read/write port address
//   PORT_RW_WR_EN    write request
//   PORT_RW_WR_BE    per-byte write enable (NBE bits)
//   PORT_RW_WR_DATA  write data
//   PORT_RW_RD_DATA  read data of the read/write port
//   PORT_R_ADDR      packed read-port addresses, port k = [k*ABITS +: ABITS]
//   PORT_R_RD_DATA   packed read-port data, port k = [k*WIDTH +: WIDTH]
//   PORT_RW_READY    array accepts writes and read data is valid
// Parameters must match those of the lut_multi_ram instance it connects to.
interface lut_multi_ram_if #(
  parameter int unsigned ABITS = 4,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned NREAD = 7,
  parameter int unsigned BYTE  = 2
);
  localparam int unsigned NBE = WIDTH / BYTE;

  logic [ABITS-1:0]       PORT_RW_ADDR;
  logic                   PORT_RW_WR_EN;
  logic [NBE-1:0]         PORT_RW_WR_BE;
  logic [WIDTH-1:0]       PORT_RW_WR_DATA;
  logic [WIDTH-1:0]       PORT_RW_RD_DATA;
  logic [NREAD*ABITS-1:0] PORT_R_ADDR;
  logic [NREAD*WIDTH-1:0] PORT_R_RD_DATA;
  logic                   PORT_RW_READY;

  modport master (
    output PORT_RW_ADDR, PORT_RW_WR_EN, PORT_RW_WR_BE, PORT_RW_WR_DATA, PORT_R_ADDR,
    input  PORT_RW_RD_DATA, PORT_R_RD_DATA, PORT_RW_READY
  );

  modport slave (
    input  PORT_RW_ADDR, PORT_RW_WR_EN, PORT_RW_WR_BE, PORT_RW_WR_DATA, PORT_R_ADDR,
    output PORT_RW_RD_DATA, PORT_R_RD_DATA, PORT_RW_READY
  );
endinterface

// File: rtl/lut_multi_ram.sv
// lut_multi_ram: DEPTH x WIDTH LUT-RAM model with one read/write port and
// NREAD read-only ports, byte-enabled writes, optional registered reads with
// selectable read-during-write transparency, and an INIT reload after reset.
//   PORT_RW_CLK     sole clock, rising edge
//   PORT_RW_ARST_N  asynchronous active-low reset
//   bus             lut_multi_ram_if slave: address/write/read/ready signals
module lut_multi_ram #(
  parameter int unsigned ABITS        = 4,
  parameter int unsigned WIDTH        = 2,
  parameter int unsigned NREAD        = 7,
  parameter int unsigned BYTE         = 2,
  parameter int unsigned RD_REG       = 0,
  parameter int unsigned TRANSPARENT  = 1,
  parameter int unsigned RESET_RELOAD = 1,
  parameter logic [(2**ABITS)*WIDTH-1:0] INIT = '0
) (
  input logic             PORT_RW_CLK,
  input logic             PORT_RW_ARST_N,
  lut_multi_ram_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ABITS;
  localparam int unsigned NBE   = WIDTH / BYTE;
  localparam int unsigned NPORT = NREAD + 1;  // port 0 is the RW port

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  localparam logic [0:0] ST_RESET    = (RESET_RELOAD != 0) ? ST_LOAD : ST_IDLE;
  localparam logic       READY_RESET = (RESET_RELOAD == 0);
  localparam logic [ABITS:0] CNT_LAST = (ABITS+1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [0:0]     state_q, state_d;
  logic [ABITS:0] cnt_q, cnt_d;
  logic           ready_q, ready_d;

  logic             load_we;
  logic             user_we;
  logic [ABITS-1:0] we_addr;
  logic [WIDTH-1:0] we_data;
  logic [NBE-1:0]   we_be;

  logic [ABITS-1:0] addr_all [NPORT];
  logic [WIDTH-1:0] raw_all  [NPORT];
  logic [WIDTH-1:0] cap_d    [NPORT];
  logic [WIDTH-1:0] rd_q     [NPORT];
  logic [WIDTH-1:0] out_all  [NPORT];

  // Reload sequencer: LOAD walks cnt over every word, IDLE is terminal.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (state_q == ST_LOAD) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge PORT_RW_CLK or negedge PORT_RW_ARST_N) begin
    if (!PORT_RW_ARST_N) begin
      state_q <= ST_RESET;
      cnt_q   <= '0;
      ready_q <= READY_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Single array write port shared by the reload sequencer and the RW port.
  // Gated by reset so clock edges while reset is held leave the array alone.
  always_comb begin
    load_we = PORT_RW_ARST_N && (state_q == ST_LOAD);
    user_we = PORT_RW_ARST_N && ready_q && !load_we && bus.PORT_RW_WR_EN;
    if (load_we) begin
      we_addr = cnt_q[ABITS-1:0];
      we_data = INIT[int'(cnt_q) * WIDTH +: WIDTH];
      we_be   = '1;
    end else begin
      we_addr = bus.PORT_RW_ADDR;
      we_data = bus.PORT_RW_WR_DATA;
      we_be   = user_we ? bus.PORT_RW_WR_BE : '0;
    end
  end

  always_ff @(posedge PORT_RW_CLK) begin
    for (int unsigned j = 0; j < NBE; j++) begin
      if (we_be[j]) begin
        mem_q[we_addr][j*BYTE +: BYTE] <= we_data[j*BYTE +: BYTE];
      end
    end
  end

  always_comb begin
    addr_all[0] = bus.PORT_RW_ADDR;
    for (int unsigned k = 0; k < NREAD; k++) begin
      addr_all[k+1] = bus.PORT_R_ADDR[k*ABITS +: ABITS];
    end
  end

  // cap_d is what a registered port captures: old word, with written bytes
  // replaced by the new data only in transparent mode.
  always_comb begin
    for (int unsigned p = 0; p < NPORT; p++) begin
      raw_all[p] = mem_q[addr_all[p]];
      cap_d[p]   = raw_all[p];
      if ((TRANSPARENT != 0) && (addr_all[p] == we_addr)) begin
        for (int unsigned j = 0; j < NBE; j++) begin
          if (we_be[j]) begin
            cap_d[p][j*BYTE +: BYTE] = we_data[j*BYTE +: BYTE];
          end
        end
      end
    end
  end

  always_ff @(posedge PORT_RW_CLK or negedge PORT_RW_ARST_N) begin
    if (!PORT_RW_ARST_N) begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NPORT; p++) begin
        rd_q[p] <= cap_d[p];
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (!ready_q) begin
        out_all[p] = '0;
      end else if (RD_REG != 0) begin
        out_all[p] = rd_q[p];
      end else begin
        out_all[p] = raw_all[p];
      end
    end
  end

  always_comb begin
    bus.PORT_R_RD_DATA = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      bus.PORT_R_RD_DATA[k*WIDTH +: WIDTH] = out_all[k+1];
    end
  end

  assign bus.PORT_RW_RD_DATA = out_all[0];
  assign bus.PORT_RW_READY   = ready_q;

endmodule

// File: tb/tb_lut_multi_ram.sv
// tb_lut_multi_ram: directed checks for lut_multi_ram across four builds:
//   A default (async reads, reload, INIT word i = i%4)
//   B WIDTH=16 BYTE=8 byte-enable build
//   C RD_REG=1 TRANSPARENT=0 RESET_RELOAD=0
//   D RD_REG=1 TRANSPARENT=1 reload of INIT word i = i%4
module tb_lut_multi_ram;
  localparam logic [31:0] INIT_MOD4 = 32'hE4E4_E4E4;

  logic clk = 1'b0;
  logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0, rst_d = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  lut_multi_ram_if #(.ABITS(4), .WIDTH(2),  .NREAD(7), .BYTE(2)) ifa ();
  lut_multi_ram_if #(.ABITS(4), .WIDTH(16), .NREAD(1), .BYTE(8)) ifb ();
  lut_multi_ram_if #(.ABITS(4), .WIDTH(2),  .NREAD(2), .BYTE(2)) ifc ();
  lut_multi_ram_if #(.ABITS(4), .WIDTH(2),  .NREAD(2), .BYTE(2)) ifd ();

  lut_multi_ram #(.ABITS(4), .WIDTH(2), .NREAD(7), .BYTE(2), .INIT(INIT_MOD4)) u_a (
    .PORT_RW_CLK(clk), .PORT_RW_ARST_N(rst_a), .bus(ifa.slave));
  lut_multi_ram #(.ABITS(4), .WIDTH(16), .NREAD(1), .BYTE(8)) u_b (
    .PORT_RW_CLK(clk), .PORT_RW_ARST_N(rst_b), .bus(ifb.slave));
  lut_multi_ram #(.ABITS(4), .WIDTH(2), .NREAD(2), .BYTE(2), .RD_REG(1),
                  .TRANSPARENT(0), .RESET_RELOAD(0)) u_c (
    .PORT_RW_CLK(clk), .PORT_RW_ARST_N(rst_c), .bus(ifc.slave));
  lut_multi_ram #(.ABITS(4), .WIDTH(2), .NREAD(2), .BYTE(2), .RD_REG(1),
                  .TRANSPARENT(1), .RESET_RELOAD(1), .INIT(INIT_MOD4)) u_d (
    .PORT_RW_CLK(clk), .PORT_RW_ARST_N(rst_d), .bus(ifd.slave));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.PORT_RW_ADDR = '0; ifa.PORT_RW_WR_EN = 1'b0; ifa.PORT_RW_WR_BE = '0;
    ifa.PORT_RW_WR_DATA = '0; ifa.PORT_R_ADDR = '0;
    ifb.PORT_RW_ADDR = '0; ifb.PORT_RW_WR_EN = 1'b0; ifb.PORT_RW_WR_BE = '0;
    ifb.PORT_RW_WR_DATA = '0; ifb.PORT_R_ADDR = '0;
    ifc.PORT_RW_ADDR = '0; ifc.PORT_RW_WR_EN = 1'b0; ifc.PORT_RW_WR_BE = '0;
    ifc.PORT_RW_WR_DATA = '0; ifc.PORT_R_ADDR = '0;
    ifd.PORT_RW_ADDR = '0; ifd.PORT_RW_WR_EN = 1'b0; ifd.PORT_RW_WR_BE = '0;
    ifd.PORT_RW_WR_DATA = '0; ifd.PORT_R_ADDR = '0;

    tick(); tick();
    check("a_rst_ready", 32'(ifa.PORT_RW_READY), 32'd0);
    check("c_rst_ready", 32'(ifc.PORT_RW_READY), 32'd1);
    check("c_rst_rd", 32'(ifc.PORT_R_RD_DATA), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

    // Reload: READY low before each of the 16 load edges, high after the 16th.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a_load_ready_%0d", i), 32'(ifa.PORT_RW_READY), 32'd0);
      tick();
    end
    check("a_ready_after_load", 32'(ifa.PORT_RW_READY), 32'd1);
    check("d_ready_after_load", 32'(ifd.PORT_RW_READY), 32'd1);

    for (int k = 0; k < 7; k++) ifa.PORT_R_ADDR[k*4 +: 4] = 4'(k);
    #1;
    for (int k = 0; k < 7; k++)
      check($sformatf("a_init_r%0d", k), 32'(ifa.PORT_R_RD_DATA[k*2 +: 2]), 32'(k % 4));

    // Async write visibility, equal-address ports, BE=0 no-op.
    ifa.PORT_RW_ADDR = 4'd5; ifa.PORT_RW_WR_EN = 1'b1; ifa.PORT_RW_WR_BE = 1'b1;
    ifa.PORT_RW_WR_DATA = 2'b10;
    tick();
    ifa.PORT_RW_WR_EN = 1'b0;
    ifa.PORT_R_ADDR[3*4 +: 4] = 4'd5;
    ifa.PORT_R_ADDR[4*4 +: 4] = 4'd5;
    #1;
    check("a_async_r3", 32'(ifa.PORT_R_RD_DATA[3*2 +: 2]), 32'd2);
    check("a_async_r4", 32'(ifa.PORT_R_RD_DATA[4*2 +: 2]), 32'd2);
    check("a_async_rw", 32'(ifa.PORT_RW_RD_DATA), 32'd2);
    ifa.PORT_RW_WR_EN = 1'b1; ifa.PORT_RW_WR_BE = 1'b0; ifa.PORT_RW_WR_DATA = 2'b11;
    tick();
    ifa.PORT_RW_WR_EN = 1'b0;
    check("a_be0_noop", 32'(ifa.PORT_RW_RD_DATA), 32'd2);

    // Byte enables on the 16-bit build.
    ifb.PORT_RW_ADDR = 4'd2; ifb.PORT_RW_WR_EN = 1'b1; ifb.PORT_RW_WR_BE = 2'b11;
    ifb.PORT_RW_WR_DATA = 16'h1234; ifb.PORT_R_ADDR = 4'd2;
    tick();
    ifb.PORT_RW_WR_BE = 2'b01; ifb.PORT_RW_WR_DATA = 16'hABCD;
    tick();
    ifb.PORT_RW_WR_EN = 1'b0;
    check("b_be_lo_rw", 32'(ifb.PORT_RW_RD_DATA), 32'h12CD);
    check("b_be_lo_r0", 32'(ifb.PORT_R_RD_DATA), 32'h12CD);
    ifb.PORT_RW_WR_EN = 1'b1; ifb.PORT_RW_WR_BE = 2'b10; ifb.PORT_RW_WR_DATA = 16'h5600;
    tick();
    ifb.PORT_RW_WR_EN = 1'b0;
    check("b_be_hi", 32'(ifb.PORT_RW_RD_DATA), 32'h56CD);

    // Registered reads: mem[3]=1, then same-edge write of 2 with R0 at addr 3.
    ifc.PORT_RW_ADDR = 4'd3; ifc.PORT_RW_WR_EN = 1'b1; ifc.PORT_RW_WR_BE = 1'b1;
    ifc.PORT_RW_WR_DATA = 2'd1; ifc.PORT_R_ADDR = {4'd0, 4'd3};
    ifd.PORT_RW_ADDR = 4'd3; ifd.PORT_RW_WR_EN = 1'b1; ifd.PORT_RW_WR_BE = 1'b1;
    ifd.PORT_RW_WR_DATA = 2'd1; ifd.PORT_R_ADDR = {4'd0, 4'd3};
    tick();
    ifc.PORT_RW_WR_DATA = 2'd2;
    ifd.PORT_RW_WR_DATA = 2'd2;
    tick();
    ifc.PORT_RW_WR_EN = 1'b0;
    ifd.PORT_RW_WR_EN = 1'b0;
    check("c_opaque_r0", 32'(ifc.PORT_R_RD_DATA[1:0]), 32'd1);
    check("c_opaque_rw", 32'(ifc.PORT_RW_RD_DATA), 32'd1);
    check("d_transp_r0", 32'(ifd.PORT_R_RD_DATA[1:0]), 32'd2);
    check("d_transp_rw", 32'(ifd.PORT_RW_RD_DATA), 32'd2);
    check("d_r1_addr0", 32'(ifd.PORT_R_RD_DATA[3:2]), 32'd0);
    tick();
    check("c_after_r0", 32'(ifc.PORT_R_RD_DATA[1:0]), 32'd2);

    // RESET_RELOAD=0: contents and READY survive reset, registered data clears.
    ifc.PORT_RW_ADDR = 4'd9; ifc.PORT_RW_WR_EN = 1'b1; ifc.PORT_RW_WR_DATA = 2'd3;
    tick();
    ifc.PORT_RW_WR_EN = 1'b0; ifc.PORT_R_ADDR = {4'd0, 4'd9};
    tick();
    check("c_r0_addr9", 32'(ifc.PORT_R_RD_DATA[1:0]), 32'd3);
    rst_c = 1'b0;
    #2;
    check("c_rst_ready_hi", 32'(ifc.PORT_RW_READY), 32'd1);
    check("c_rst_r0_zero", 32'(ifc.PORT_R_RD_DATA[1:0]), 32'd0);
    check("c_rst_rw_zero", 32'(ifc.PORT_RW_RD_DATA), 32'd0);
    rst_c = 1'b1;
    tick();
    check("c_mem9_kept", 32'(ifc.PORT_R_RD_DATA[1:0]), 32'd3);

    // Mid-load reset on A, then a write attempt during the restarted load.
    rst_a = 1'b0;
    #1;
    check("a_rst_ready_lo", 32'(ifa.PORT_RW_READY), 32'd0);
    check("a_rst_r3_zero", 32'(ifa.PORT_R_RD_DATA[3*2 +: 2]), 32'd0);
    tick();
    rst_a = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_a = 1'b0;
    #1;
    check("a_midload_ready", 32'(ifa.PORT_RW_READY), 32'd0);
    tick();
    rst_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a_reload_ready_%0d", i), 32'(ifa.PORT_RW_READY), 32'd0);
      ifa.PORT_RW_WR_EN = (i == 9);
      ifa.PORT_RW_ADDR = 4'd5; ifa.PORT_RW_WR_BE = 1'b1; ifa.PORT_RW_WR_DATA = 2'd3;
      tick();
    end
    ifa.PORT_RW_WR_EN = 1'b0;
    check("a_reload_ready", 32'(ifa.PORT_RW_READY), 32'd1);
    check("a_dropped_write", 32'(ifa.PORT_RW_RD_DATA), 32'd1);
    for (int k = 0; k < 7; k++) ifa.PORT_R_ADDR[k*4 +: 4] = 4'(k + 8);
    ifa.PORT_RW_ADDR = 4'd15;
    #1;
    for (int k = 0; k < 7; k++)
      check($sformatf("a_reinit_r%0d", k), 32'(ifa.PORT_R_RD_DATA[k*2 +: 2]), 32'((k + 8) % 4));
    check("a_reinit_w15", 32'(ifa.PORT_RW_RD_DATA), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
